// File: rtl/gf2m_serial_mult_if.sv
// Operand/result bundle for the GF(2^M) serial multiplier.
// master = requester (point-arithmetic sequencer), slave = multiplier.
interface gf2m_serial_mult_if #(
  parameter int M = 233
);
  logic         start;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         ready;
  logic         done;
  logic [M-1:0] Out;

  modport master (
    output start, A, B,
    input  ready, done, Out
  );

  modport slave (
    input  start, A, B,
    output ready, done, Out
  );
endinterface

// File: rtl/gf2m_serial_mult.sv
// Bit-serial, MSB-first GF(2^M) multiplier, product = A*B mod (x^M + POLY).
// Optional macro GF2M_MULT_DIGIT2_EN: consume two multiplier bits per step
// (radix-4 digit-serial, ceil(M/2) steps). Results are identical either way.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1 (ready is high only in IDLE); A and B are sampled on that edge and
// may change afterwards. start while ready=0 is dropped, never queued.
// done is a one-cycle pulse; Out is valid from that cycle and holds until
// the next completion or reset. Reset wins over a coincident start.
module gf2m_serial_mult #(
  parameter int           M    = 233,
  parameter logic [M-1:0] POLY = M'(1) | (M'(1) << 74)
) (
  input  logic                clk,
  input  logic                rst,
  gf2m_serial_mult_if.slave   bus,
  output logic [1:0]          state_dbg
);

`ifdef GF2M_MULT_DIGIT2_EN
  localparam int STEPS = (M + 1) / 2;
  // Odd M gets one leading zero so every step sees a full 2-bit digit.
  localparam int BW    = 2 * STEPS;
`else
  localparam int STEPS = M;
  localparam int BW    = M;
`endif
  localparam int CW = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [M-1:0]  a_reg;
  logic [BW-1:0] b_reg, b_n;
  logic [M-1:0]  acc, acc_n;
  logic [M-1:0]  out_reg;
  logic [CW-1:0] cnt;

  // Multiply by x and fold the x^M term back in; result has degree < M.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    xtime = {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  // One Horner step on the accumulator, consuming the current multiplier MSB(s).
  always_comb begin
`ifdef GF2M_MULT_DIGIT2_EN
    acc_n = xtime(xtime(acc) ^ (b_reg[BW-1] ? a_reg : '0))
            ^ (b_reg[BW-2] ? a_reg : '0);
    b_n   = b_reg << 2;
`else
    acc_n = xtime(acc) ^ (b_reg[BW-1] ? a_reg : '0);
    b_n   = b_reg << 1;
`endif
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: fixed STEPS iterations regardless of operand values.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = BUSY;
      BUSY:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, serial iteration, and result register load.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.A;
            b_reg <= BW'(bus.B);
            acc   <= '0;
            cnt   <= CW'(STEPS - 1);
          end
        end
        BUSY: begin
          acc   <= acc_n;
          b_reg <= b_n;
          if (cnt != '0) cnt <= cnt - CW'(1);
          // Last step: the registered result is loaded on entry into DONE.
          if (cnt == '0) out_reg <= acc_n;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);
  assign bus.Out   = out_reg;
  assign state_dbg = state;

endmodule

// File: tb/tb_gf2m_serial_mult.sv
// Testbench for gf2m_serial_mult at M=233 (x^233 + x^74 + 1).
// Directed vector table, randomized products against a schoolbook reference,
// mid-operation start, reset abort, and back-to-back timing sequences.
module tb_gf2m_serial_mult;
  localparam int M = 233;
  localparam logic [M-1:0] POLY = M'(1) | (M'(1) << 74);
`ifdef GF2M_MULT_DIGIT2_EN
  localparam int STEPS = (M + 1) / 2;
`else
  localparam int STEPS = M;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2m_serial_mult_if #(.M(M)) bus ();

  gf2m_serial_mult #(.M(M), .POLY(POLY)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  logic [M-1:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Pops one expected product per done pulse; a pulse with nothing pending is an error.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (cyc %0d)", cyc);
      end else begin
        logic [M-1:0] e;
        e = exp_q.pop_front();
        check("product", 256'(bus.Out), 256'(e));
      end
    end
  end

  // ---------------- reference model ----------------
  // Full carry-less product, then reduce from the top bit down.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) p ^= ({{(M-1){1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p ^= ({{(M-1){1'b0}}, POLY} << (i - M));
      end
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [255:0] t;
    for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
    return t[M-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  int k_acc;

  // Present a request for one cycle; it is accepted on the following edge.
  task automatic launch(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] e);
    @(negedge clk);
    check("ready_before_start", 256'(bus.ready), 256'(1));
    bus.A = a; bus.B = b; bus.start = 1'b1;
    k_acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = rand_elem(); bus.B = rand_elem();
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < STEPS + 10) begin
      @(negedge clk);
      n++;
    end
    seen = (bus.done === 1'b1);
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", STEPS + 10);
    end
  endtask

  task automatic finish_op();
    bit seen;
    wait_done(seen);
    if (seen) begin
      check("latency", 256'(cyc - k_acc), 256'(STEPS));
      @(negedge clk);
      check("ready_after_done", 256'(bus.ready), 256'(1));
      check("done_one_cycle", 256'(bus.done), 256'(0));
    end
  endtask

  task automatic do_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] e);
    launch(a, b, e);
    finish_op();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] e;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [M-1:0] ones, a1, b1, a2, b2;
    int d1, d2, dc;
    bit seen;

    ones = '1;
    vecs[0] = '{a: M'(1),          b: M'(1),          e: M'(1)};
    vecs[1] = '{a: M'(2),          b: M'(1) << 232,   e: (M'(1) << 74) | M'(1)};
    vecs[2] = '{a: '0,             b: ones,           e: '0};
    vecs[3] = '{a: ones,           b: '0,             e: '0};
    vecs[4] = '{a: M'(1) << 116,   b: M'(1) << 116,   e: M'(1) << 232};
    vecs[5] = '{a: M'(1) << 232,   b: M'(1) << 232,
                e: (M'(1) << 231) | (M'(1) << 146) | (M'(1) << 72)};
    vecs[6] = '{a: ones,           b: M'(1),          e: ones};

    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("reset_ready", 256'(bus.ready), 256'(1));
    check("reset_done",  256'(bus.done),  256'(0));
    check("reset_out",   256'(bus.Out),   256'(0));
    check("reset_state", 256'(state_dbg), 256'(0));

    // Directed table.
    for (int i = 0; i < 7; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].e);

    // Random products, with a swapped-operand repeat for commutativity.
    for (int i = 0; i < 100; i++) begin
      a1 = rand_elem(); b1 = rand_elem();
      do_op(a1, b1, ref_mul(a1, b1));
      if (i < 20) do_op(b1, a1, ref_mul(a1, b1));
    end

    // start pulsed mid-operation with different operands must be ignored.
    a1 = rand_elem(); b1 = rand_elem();
    dc = done_cnt;
    launch(a1, b1, ref_mul(a1, b1));
    repeat (50) @(negedge clk);
    check("ready_low_busy", 256'(bus.ready), 256'(0));
    bus.A = rand_elem(); bus.B = rand_elem(); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op();
    repeat (STEPS + 5) @(negedge clk);
    check("single_done", 256'(done_cnt - dc), 256'(1));

    // Reset at step 100 together with start: abort, no done, clean restart.
    a1 = rand_elem(); b1 = rand_elem();
    launch(a1, b1, ref_mul(a1, b1));
    repeat (99) @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.A = rand_elem(); bus.B = rand_elem();
    exp_q.delete();
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("abort_ready", 256'(bus.ready), 256'(1));
    check("abort_done",  256'(bus.done),  256'(0));
    check("abort_out",   256'(bus.Out),   256'(0));
    check("abort_state", 256'(state_dbg), 256'(0));
    repeat (STEPS + 5) @(negedge clk);
    check("abort_no_done", 256'(done_cnt - dc), 256'(0));
    a1 = rand_elem(); b1 = rand_elem();
    do_op(a1, b1, ref_mul(a1, b1));

    // Back-to-back with start held high: not accepted in DONE.
    a1 = rand_elem(); b1 = rand_elem();
    a2 = rand_elem(); b2 = rand_elem();
    @(negedge clk);
    bus.A = a1; bus.B = b1; bus.start = 1'b1;
    k_acc = cyc + 1;
    exp_q.push_back(ref_mul(a1, b1));
    exp_q.push_back(ref_mul(a2, b2));
    @(negedge clk);
    bus.A = a2; bus.B = b2;
    wait_done(seen);
    d1 = cyc;
    check("b2b_latency1", 256'(d1 - k_acc), 256'(STEPS));
    @(negedge clk);
    check("b2b_ready", 256'(bus.ready), 256'(1));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(seen);
    d2 = cyc;
    check("b2b_done_spacing", 256'(d2 - d1), 256'(STEPS + 2));
    repeat (3) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
